// File: rtl/hcsr04_pkg.sv
// Shared HC-SR04 definitions: FSM state codes, debug codes and default timing constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hcsr04_pkg;

  // State codes double as the db_estado debug value.
  typedef enum logic [3:0] {
    EST_OCIOSO        = 4'b0000,
    EST_MEDE_TRIGGER  = 4'b0001,
    EST_ESPERA_RAJADA = 4'b0010,
    EST_GERA_ECHO     = 4'b0011,
    EST_INTERVALO     = 4'b0100
  } estado_t;

  // Reported on db_estado when the state register holds an unused code.
  localparam logic [3:0] DB_INVALIDO = 4'b1110;

  // Default timing at 50 MHz, shared with interface_hcsr04 and its benches.
  localparam int PAD_CICLOS_TRIG_MIN  = 500;
  localparam int PAD_CICLOS_RAJADA    = 10000;
  localparam int PAD_CICLOS_CM        = 2941;
  localparam int PAD_DIST_MIN         = 2;
  localparam int PAD_DIST_MAX         = 400;
  localparam int PAD_CICLOS_TIMEOUT   = 1900000;
  localparam int PAD_CICLOS_INTERVALO = 500000;

  localparam int DIST_BITS = 9;

  function automatic int maior(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to hold 0..m-1, never less than one.
  function automatic int largura(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/contador_m.sv
// Generic modulo-M counter: zera clears, conta advances, fim flags the last value M-1.
// Latency: q updates on the clock edge after zera/conta; fim is combinational from q.
// Backpressure: none; counting past M-1 wraps to 0, so callers gate conta where that matters.
module contador_m #(
  parameter int M = 16,
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         zera,
  input  logic         conta,
  output logic [W-1:0] q,
  output logic         fim
);

  assign fim = (q == W'(M - 1));

  // Count register; zera has priority over conta.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (zera) begin
      q <= '0;
    end else if (conta) begin
      q <= fim ? '0 : q + W'(1);
    end
  end

endmodule

// File: rtl/hcsr04_emulador.sv
// HC-SR04 responder: validates trigger width, waits the burst time, then drives echo for d*CICLOS_CM clocks.
// Latency: trigger pin to FSM 2 clocks; echo rises CICLOS_RAJADA clocks after synchronized trigger falls.
// Backpressure: none; triggers arriving outside ocioso are dropped, never queued.
module hcsr04_emulador
  import hcsr04_pkg::*;
#(
  parameter int CICLOS_TRIG_MIN  = PAD_CICLOS_TRIG_MIN,
  parameter int CICLOS_RAJADA    = PAD_CICLOS_RAJADA,
  parameter int CICLOS_CM        = PAD_CICLOS_CM,
  parameter int DIST_MIN         = PAD_DIST_MIN,
  parameter int DIST_MAX         = PAD_DIST_MAX,
  parameter int CICLOS_TIMEOUT   = PAD_CICLOS_TIMEOUT,
  parameter int CICLOS_INTERVALO = PAD_CICLOS_INTERVALO
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 habilita,
  input  logic                 trigger,
  input  logic [DIST_BITS-1:0] distancia,
  output logic                 echo,
  output logic                 erro_trigger,
  output logic                 ocupado,
  output logic [3:0]           db_estado
);

  // One counter is shared by rajada, timeout echo and intervalo since they never overlap.
  localparam int FASE_M  = maior(maior(CICLOS_RAJADA, CICLOS_TIMEOUT), CICLOS_INTERVALO);
  localparam int W_LARG  = largura(CICLOS_TRIG_MIN + 1);
  localparam int W_FASE  = largura(FASE_M);
  localparam int W_INTRA = largura(CICLOS_CM);
  localparam int W_CM    = largura(DIST_MAX);

  estado_t estado, prox;

  logic trig_m, trig_s, trig_d;
  logic [DIST_BITS-1:0] dist_lat;
  logic modo_timeout;
  logic captura;
  logic erro_curto;

  logic larg_zera, larg_conta, larg_fim;
  logic fase_zera, fase_conta;
  logic intra_zera, intra_conta, intra_fim;
  logic cm_zera, cm_conta;

  logic [W_LARG-1:0]  unused_larg_q;
  logic [W_FASE-1:0]  fase_q;
  logic               unused_fase_fim;
  logic [W_INTRA-1:0] unused_intra_q;
  logic [W_CM-1:0]    cm_q;
  logic               unused_cm_fim;

  // Trigger width, saturating at CICLOS_TRIG_MIN (modulus MIN+1 so fim means "long enough").
  contador_m #(.M(CICLOS_TRIG_MIN + 1), .W(W_LARG)) u_cont_largura (
    .clock (clock), .reset (reset), .zera (larg_zera), .conta (larg_conta),
    .q (unused_larg_q), .fim (larg_fim)
  );

  contador_m #(.M(FASE_M), .W(W_FASE)) u_cont_fase (
    .clock (clock), .reset (reset), .zera (fase_zera), .conta (fase_conta),
    .q (fase_q), .fim (unused_fase_fim)
  );

  contador_m #(.M(CICLOS_CM), .W(W_INTRA)) u_cont_intra (
    .clock (clock), .reset (reset), .zera (intra_zera), .conta (intra_conta),
    .q (unused_intra_q), .fim (intra_fim)
  );

  contador_m #(.M(DIST_MAX), .W(W_CM)) u_cont_cm (
    .clock (clock), .reset (reset), .zera (cm_zera), .conta (cm_conta),
    .q (cm_q), .fim (unused_cm_fim)
  );

  // Two-flop synchronizer plus one delayed copy for rising-edge detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      trig_m <= 1'b0;
      trig_s <= 1'b0;
      trig_d <= 1'b0;
    end else begin
      trig_m <= trigger;
      trig_s <= trig_m;
      trig_d <= trig_s;
    end
  end

  // State register and registered outputs; reset clears echo without a clock edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado       <= EST_OCIOSO;
      echo         <= 1'b0;
      erro_trigger <= 1'b0;
    end else begin
      estado       <= prox;
      echo         <= (prox == EST_GERA_ECHO);
      erro_trigger <= erro_curto;
    end
  end

  // Distance latch at t0: clamp short distances, flag out-of-range ones for the timeout echo.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dist_lat     <= '0;
      modo_timeout <= 1'b0;
    end else if (captura) begin
      modo_timeout <= (32'(distancia) > DIST_MAX);
      if (32'(distancia) < DIST_MIN) begin
        dist_lat <= DIST_BITS'(DIST_MIN);
      end else begin
        dist_lat <= distancia;
      end
    end
  end

  // Next-state and counter control; every counter is held cleared unless its phase is active.
  always_comb begin
    prox        = estado;
    captura     = 1'b0;
    erro_curto  = 1'b0;
    larg_zera   = 1'b1;
    larg_conta  = 1'b0;
    fase_zera   = 1'b1;
    fase_conta  = 1'b0;
    intra_zera  = 1'b1;
    intra_conta = 1'b0;
    cm_zera     = 1'b1;
    cm_conta    = 1'b0;
    case (estado)
      EST_OCIOSO: begin
        // A trigger still high from before must fall and rise again to be accepted.
        if (habilita && trig_s && !trig_d) begin
          prox       = EST_MEDE_TRIGGER;
          larg_zera  = 1'b0;
          larg_conta = 1'b1;
        end
      end
      EST_MEDE_TRIGGER: begin
        larg_zera = 1'b0;
        if (trig_s) begin
          larg_conta = !larg_fim;
        end else if (larg_fim) begin
          // The t0 cycle already counts as the first rajada clock.
          prox       = EST_ESPERA_RAJADA;
          captura    = 1'b1;
          fase_zera  = 1'b0;
          fase_conta = 1'b1;
        end else begin
          prox       = EST_OCIOSO;
          erro_curto = 1'b1;
        end
      end
      EST_ESPERA_RAJADA: begin
        fase_zera  = 1'b0;
        fase_conta = 1'b1;
        if (32'(fase_q) == CICLOS_RAJADA - 1) begin
          prox      = EST_GERA_ECHO;
          fase_zera = 1'b1;
        end
      end
      EST_GERA_ECHO: begin
        if (modo_timeout) begin
          fase_zera  = 1'b0;
          fase_conta = 1'b1;
          if (32'(fase_q) == CICLOS_TIMEOUT - 1) begin
            prox      = EST_INTERVALO;
            fase_zera = 1'b1;
          end
        end else begin
          intra_zera  = 1'b0;
          intra_conta = 1'b1;
          cm_zera     = 1'b0;
          cm_conta    = intra_fim;
          if (intra_fim && (32'(cm_q) == 32'(dist_lat) - 32'd1)) begin
            prox = EST_INTERVALO;
          end
        end
      end
      EST_INTERVALO: begin
        fase_zera  = 1'b0;
        fase_conta = 1'b1;
        if (32'(fase_q) == CICLOS_INTERVALO - 1) begin
          prox = EST_OCIOSO;
        end
      end
      default: begin
        prox = EST_OCIOSO;
      end
    endcase
  end

  // Status decode: busy outside ocioso, unused codes reported as invalid.
  always_comb begin
    ocupado   = (estado != EST_OCIOSO);
    db_estado = DB_INVALIDO;
    case (estado)
      EST_OCIOSO, EST_MEDE_TRIGGER, EST_ESPERA_RAJADA, EST_GERA_ECHO, EST_INTERVALO:
        db_estado = estado;
      default:
        db_estado = DB_INVALIDO;
    endcase
  end

endmodule

// File: tb/tb_hcsr04_emulador.sv
// Directed/randomized bench for hcsr04_emulador with a timing reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_hcsr04_emulador;

  localparam int TMIN = 5;
  localparam int RAJ  = 10;
  localparam int CMC  = 4;
  localparam int DMIN = 2;
  localparam int DMAX = 400;
  localparam int TOUT = 50;
  localparam int INTV = 20;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       habilita = 1'b1;
  logic       trigger = 1'b0;
  logic [8:0] distancia = '0;
  logic       echo, erro_trigger, ocupado;
  logic [3:0] db_estado;

  int vectors = 0;
  int miscompares = 0;

  // Observation record, filled shortly after each rising clock edge.
  int cyc = 0;
  int rises, rise_cyc, fall_cyc, ocup_fall_cyc, erro_hi, erro_cyc, ocup_hi;
  bit ocup_fell;
  bit echo_ant = 1'b0;
  bit ocup_ant = 1'b0;

  hcsr04_emulador #(
    .CICLOS_TRIG_MIN (TMIN), .CICLOS_RAJADA (RAJ), .CICLOS_CM (CMC), .DIST_MIN (DMIN),
    .DIST_MAX (DMAX), .CICLOS_TIMEOUT (TOUT), .CICLOS_INTERVALO (INTV)
  ) dut (
    .clock (clock), .reset (reset), .habilita (habilita), .trigger (trigger),
    .distancia (distancia), .echo (echo), .erro_trigger (erro_trigger),
    .ocupado (ocupado), .db_estado (db_estado)
  );

  always #5 clock = ~clock;

  // Monitor: timestamps echo edges, busy fall and error pulses by clock index.
  always @(posedge clock) begin
    cyc++;
    #1;
    if (echo === 1'b1 && !echo_ant) begin rises++; rise_cyc = cyc; end
    if (echo === 1'b0 && echo_ant) fall_cyc = cyc;
    if (ocupado === 1'b0 && ocup_ant) begin ocup_fell = 1'b1; ocup_fall_cyc = cyc; end
    if (ocupado === 1'b1) ocup_hi++;
    if (erro_trigger === 1'b1) begin erro_hi++; erro_cyc = cyc; end
    echo_ant = (echo === 1'b1);
    ocup_ant = (ocupado === 1'b1);
  end

  // Reference model: echo width from the distance rules.
  function automatic int largura_esperada(input int d);
    if (d > DMAX) return TOUT;
    if (d < DMIN) return DMIN * CMC;
    return d * CMC;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    rises = 0; rise_cyc = -1; fall_cyc = -1; ocup_fall_cyc = -1;
    erro_hi = 0; erro_cyc = -1; ocup_hi = 0; ocup_fell = 1'b0;
  endtask

  // Called at a falling edge; trigger is sampled high by exactly n rising edges.
  task automatic pulse(input int n, output int tf);
    trigger = 1'b1;
    repeat (n) @(negedge clock);
    trigger = 1'b0;
    tf = cyc;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 4000; i++) begin
      if (ocup_fell) break;
      @(negedge clock);
    end
    chk($sformatf("%s idle", tag), 32'(ocup_fell), 1);
  endtask

  // Full valid cycle: rise time, width, dead time, no error flag.
  task automatic run_valid(input int d, input int n, input string tag);
    int tf;
    distancia = 9'(d);
    clr();
    pulse(n, tf);
    wait_idle(tag);
    chk($sformatf("%s rises", tag), rises, 1);
    chk($sformatf("%s rise", tag), rise_cyc, tf + 2 + RAJ);
    chk($sformatf("%s width d=%0d", tag, d), fall_cyc - rise_cyc, largura_esperada(d));
    chk($sformatf("%s intervalo", tag), ocup_fall_cyc - fall_cyc, INTV);
    chk($sformatf("%s erro", tag), erro_hi, 0);
    chk($sformatf("%s estado", tag), 32'(db_estado), 0);
  endtask

  task automatic run_short(input int n, input string tag);
    int tf;
    clr();
    pulse(n, tf);
    wait_idle(tag);
    chk($sformatf("%s erro pulses", tag), erro_hi, 1);
    chk($sformatf("%s erro time", tag), erro_cyc, tf + 3);
    repeat (RAJ + 10) @(negedge clock);
    chk($sformatf("%s no echo", tag), rises, 0);
    chk($sformatf("%s estado", tag), 32'(db_estado), 0);
  endtask

  initial begin
    int tf, tf2, d;
    clr();
    repeat (3) @(negedge clock);
    chk("reset echo", 32'(echo), 0);
    chk("reset erro", 32'(erro_trigger), 0);
    chk("reset ocupado", 32'(ocupado), 0);
    chk("reset estado", 32'(db_estado), 0);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    run_valid(25, 6, "basic");
    run_short(3, "short3");
    run_valid(30, TMIN, "min width");
    run_short(TMIN - 1, "short4");
    run_short(1, "short1");
    run_valid(0, 6, "d0");
    run_valid(450, 6, "d450");
    run_valid(1, 6, "d1");
    run_valid(DMIN, 6, "dmin");
    run_valid(DMAX, 6, "dmax");
    run_valid(DMAX + 1, 6, "dmax+1");
    run_valid(511, 6, "d511");
    run_valid(25, 40, "long trig");

    for (int k = 0; k < 6; k++) begin
      run_valid(int'($urandom_range(0, 511)), int'($urandom_range(TMIN, TMIN + 4)), $sformatf("rnd%0d", k));
      run_short(int'($urandom_range(1, TMIN - 1)), $sformatf("rnd short%0d", k));
    end

    // habilita low: trigger ignored entirely.
    habilita = 1'b0;
    clr();
    pulse(6, tf);
    repeat (30) @(negedge clock);
    chk("hab0 rises", rises, 0);
    chk("hab0 busy", ocup_hi, 0);
    habilita = 1'b1;
    repeat (3) @(negedge clock);

    // Second trigger while echo is high is ignored.
    distancia = 9'd25;
    clr();
    pulse(6, tf);
    repeat (10) @(negedge clock);
    pulse(6, tf2);
    wait_idle("retrig");
    chk("retrig rises", rises, 1);
    chk("retrig rise", rise_cyc, tf + 2 + RAJ);
    chk("retrig width", fall_cyc - rise_cyc, 100);
    chk("retrig erro", erro_hi, 0);
    chk("retrig tf2 inside echo", 32'(tf2 < fall_cyc), 1);

    // Trigger rising in intervalo and held past its end is not accepted.
    distancia = 9'd10;
    clr();
    pulse(6, tf);
    repeat (60) @(negedge clock);
    trigger = 1'b1;
    repeat (60) @(negedge clock);
    chk("held rises", rises, 1);
    chk("held busy end", ocup_fall_cyc - tf, 2 + RAJ + 10 * CMC + INTV);
    chk("held ocupado", 32'(ocupado), 0);
    chk("held estado", 32'(db_estado), 0);
    chk("held erro", erro_hi, 0);
    trigger = 1'b0;
    repeat (3) @(negedge clock);
    run_valid(int'($urandom_range(0, 60)), 7, "rearm");

    // distancia and habilita changed during espera_rajada do not affect the cycle.
    distancia = 9'd25;
    clr();
    pulse(6, tf);
    repeat (5) @(negedge clock);
    distancia = 9'd3;
    habilita = 1'b0;
    wait_idle("dchg");
    chk("dchg rise", rise_cyc, tf + 2 + RAJ);
    chk("dchg width", fall_cyc - rise_cyc, 100);
    chk("dchg intervalo", ocup_fall_cyc - fall_cyc, INTV);
    habilita = 1'b1;
    repeat (3) @(negedge clock);

    // Reset mid-echo acts without a clock edge.
    distancia = 9'd25;
    clr();
    pulse(6, tf);
    repeat (20) @(negedge clock);
    chk("pre-reset echo", 32'(echo), 1);
    #2 reset = 1'b1;
    #1;
    chk("async reset echo", 32'(echo), 0);
    chk("async reset estado", 32'(db_estado), 0);
    chk("async reset ocupado", 32'(ocupado), 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    d = int'($urandom_range(0, 511));
    run_valid(d, 6, "post reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
